// File: rtl/ac97_dma_arb_if.sv
// DMA request/acknowledge bus between the AC97 channel scheduler and the system DMA engine.
interface ac97_dma_arb_if #(
  parameter int unsigned CH_W = 4
) ();
  logic            dma_req;
  logic [CH_W-1:0] dma_ch;
  logic            dma_last;
  logic            dma_ack;

  modport master (output dma_req, output dma_ch, output dma_last, input dma_ack);
  modport slave  (input dma_req, input dma_ch, input dma_last, output dma_ack);
endinterface

// File: rtl/ac97_dma_arb.sv
// Round-robin scheduler sharing one DMA engine across the nine AC97 FIFO channels.
// Optional macro AC97_DMA_IN_PRIO_EN: capture channels [6..8] get strict priority over playback.
module ac97_dma_arb #(
  parameter int unsigned NCH      = 9,
  parameter int unsigned CH_W     = 4,
  parameter int unsigned TOUT_CYC = 255,
  parameter int unsigned TOUT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  ch_req,
  input  logic [NCH-1:0]  ch_en,
  input  logic [3:0]      burst_len,
  ac97_dma_arb_if.master  dma,
  output logic [NCH-1:0]  ch_grant,
  output logic            busy,
  output logic            tout_err,
  output logic [CH_W-1:0] tout_ch
);

  localparam int unsigned LEN_W = 4;
  localparam int unsigned IN_LO = 6;

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   win, win_nxt;
  logic [LEN_W-1:0]  beats_m1, beats_m1_nxt;
  logic [LEN_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [TOUT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              req_q, req_nxt;
  logic              last_q, last_nxt;
  logic [NCH-1:0]    ch_grant_nxt;
  logic              busy_nxt;
  logic              tout_err_nxt;
  logic [CH_W-1:0]   tout_ch_nxt;

  logic [NCH-1:0]    elig;
  logic [CH_W:0]     pick;
  logic              ack_last;
  logic              trunc;
  logic              tout_hit;
  logic              xfer_exit;

`ifdef AC97_DMA_IN_PRIO_EN
  logic [CH_W-1:0]   in_ptr, in_ptr_nxt;
  logic [CH_W-1:0]   out_ptr, out_ptr_nxt;
`else
  logic [CH_W-1:0]   rr_ptr, rr_ptr_nxt;
`endif

  // First requesting channel at or above ptr within [lo..hi], wrapping; MSB flags a hit.
  function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0] req, input int lo,
                                            input int hi, input logic [CH_W-1:0] ptr);
    logic [CH_W:0] res;
    int            span;
    int            idx;
    res  = '0;
    span = hi - lo + 1;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = lo + ((int'(ptr) - lo + k) % span);
      if (req[idx[CH_W-1:0]]) res = {1'b1, idx[CH_W-1:0]};
    end
    return res;
  endfunction

  assign dma.dma_req  = req_q;
  assign dma.dma_ch   = win;
  assign dma.dma_last = last_q;

  always_comb begin : pick_comb
    elig = ch_req & ch_en;
`ifdef AC97_DMA_IN_PRIO_EN
    if (|elig[NCH-1:IN_LO]) pick = rr_pick(elig, IN_LO, NCH - 1, in_ptr);
    else                    pick = rr_pick(elig, 0, IN_LO - 1, out_ptr);
`else
    pick = rr_pick(elig, 0, NCH - 1, rr_ptr);
`endif
  end

  // Burst exit conditions; truncation outranks timeout, completion outranks both.
  always_comb begin : exit_comb
    ack_last  = dma.dma_ack && last_q;
    trunc     = !(ch_req[win] && ch_en[win]);
    tout_hit  = !dma.dma_ack && !trunc && (wait_cnt == TOUT_W'(TOUT_CYC - 1));
    xfer_exit = ack_last || trunc || tout_hit;
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      state    <= IDLE;
      win      <= '0;
      beats_m1 <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      req_q    <= 1'b0;
      last_q   <= 1'b0;
      ch_grant <= '0;
      busy     <= 1'b0;
      tout_err <= 1'b0;
      tout_ch  <= '0;
`ifdef AC97_DMA_IN_PRIO_EN
      in_ptr   <= CH_W'(IN_LO);
      out_ptr  <= '0;
`else
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      win      <= win_nxt;
      beats_m1 <= beats_m1_nxt;
      beat_cnt <= beat_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      req_q    <= req_nxt;
      last_q   <= last_nxt;
      ch_grant <= ch_grant_nxt;
      busy     <= busy_nxt;
      tout_err <= tout_err_nxt;
      tout_ch  <= tout_ch_nxt;
`ifdef AC97_DMA_IN_PRIO_EN
      in_ptr   <= in_ptr_nxt;
      out_ptr  <= out_ptr_nxt;
`else
      rr_ptr   <= rr_ptr_nxt;
`endif
    end
  end

  always_comb begin : next_state_comb
    state_nxt = state;
    case (state)
      IDLE:    if (pick[CH_W]) state_nxt = XFER;
      XFER:    if (xfer_exit) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : output_comb
    win_nxt      = win;
    beats_m1_nxt = beats_m1;
    beat_cnt_nxt = beat_cnt;
    wait_cnt_nxt = wait_cnt;
    req_nxt      = 1'b0;
    last_nxt     = 1'b0;
    ch_grant_nxt = '0;
    busy_nxt     = (state_nxt != IDLE);
    tout_err_nxt = 1'b0;
    tout_ch_nxt  = tout_ch;
`ifdef AC97_DMA_IN_PRIO_EN
    in_ptr_nxt   = in_ptr;
    out_ptr_nxt  = out_ptr;
`else
    rr_ptr_nxt   = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (pick[CH_W]) begin
          win_nxt      = pick[CH_W-1:0];
          beats_m1_nxt = burst_len;
          beat_cnt_nxt = '0;
          wait_cnt_nxt = '0;
          req_nxt      = 1'b1;
          last_nxt     = (burst_len == '0);
          ch_grant_nxt = NCH'(1) << pick[CH_W-1:0];
        end
      end
      XFER: begin
        if (xfer_exit) begin
`ifdef AC97_DMA_IN_PRIO_EN
          if (win >= CH_W'(IN_LO))
            in_ptr_nxt = (win == CH_W'(NCH - 1)) ? CH_W'(IN_LO) : win + CH_W'(1);
          else
            out_ptr_nxt = (win == CH_W'(IN_LO - 1)) ? '0 : win + CH_W'(1);
`else
          rr_ptr_nxt = (win == CH_W'(NCH - 1)) ? '0 : win + CH_W'(1);
`endif
          if (tout_hit) begin
            tout_err_nxt = 1'b1;
            tout_ch_nxt  = win;
          end
        end else begin
          req_nxt      = 1'b1;
          ch_grant_nxt = NCH'(1) << win;
          if (dma.dma_ack) begin
            beat_cnt_nxt = beat_cnt + LEN_W'(1);
            wait_cnt_nxt = '0;
            last_nxt     = ((beat_cnt + LEN_W'(1)) == beats_m1);
          end else begin
            wait_cnt_nxt = wait_cnt + TOUT_W'(1);
            last_nxt     = last_q;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ac97_dma_arb.sv
// Randomized self-checking bench for ac97_dma_arb against a burst-level scheduler model.
module tb_ac97_dma_arb;

  localparam int TOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] ch_req;
  logic [8:0] ch_en;
  logic [3:0] burst_len;
  logic [8:0] ch_grant;
  logic       busy;
  logic       tout_err;
  logic [3:0] tout_ch;

  ac97_dma_arb_if bus ();

  ac97_dma_arb dut (
    .clk       (clk),
    .rst       (rst),
    .ch_req    (ch_req),
    .ch_en     (ch_en),
    .burst_len (burst_len),
    .dma       (bus),
    .ch_grant  (ch_grant),
    .busy      (busy),
    .tout_err  (tout_err),
    .tout_ch   (tout_ch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model scheduler state
  int mptr, in_ptr, out_ptr, mt_ch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr = 0; in_ptr = 6; out_ptr = 0; mt_ch = 0;
  endtask

  function automatic int model_pick(input logic [8:0] e);
`ifdef AC97_DMA_IN_PRIO_EN
    if (e[8:6] != 3'b000) begin
      for (int k = 0; k < 3; k++) if (e[6 + ((in_ptr - 6 + k) % 3)]) return 6 + ((in_ptr - 6 + k) % 3);
    end else begin
      for (int k = 0; k < 6; k++) if (e[(out_ptr + k) % 6]) return (out_ptr + k) % 6;
    end
`else
    for (int k = 0; k < 9; k++) if (e[(mptr + k) % 9]) return (mptr + k) % 9;
`endif
    return -1;
  endfunction

  task automatic model_advance(input int w);
`ifdef AC97_DMA_IN_PRIO_EN
    if (w >= 6) in_ptr = 6 + ((w - 5) % 3);
    else        out_ptr = (w + 1) % 6;
`else
    mptr = (w + 1) % 9;
`endif
  endtask

  // Starts at a negedge inside an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic do_burst(input logic [8:0] req, input logic [8:0] en, input int blen,
                          input int ack_pct, input int drop_after, input string tag);
    int         w, beats, nack, cyc;
    bit         done, tout, ack, drop;
    logic [8:0] oh, r, e;
    ch_req      = req;
    ch_en       = en;
    burst_len   = 4'(blen);
    bus.dma_ack = 1'($urandom_range(0, 1));
    w    = model_pick(req & en);
    oh   = 9'(1) << w;
    beats = 0; nack = 0; cyc = 0; done = 0; tout = 0;
    @(negedge clk);
    while (!done && cyc < 5000) begin
      cyc++;
      chk({tag, "_req"},  32'(bus.dma_req),  32'd1);
      chk({tag, "_ch"},   32'(bus.dma_ch),   32'(w));
      chk({tag, "_gnt"},  32'(ch_grant),     32'(oh));
      chk({tag, "_last"}, 32'(bus.dma_last), 32'(beats == blen));
      chk({tag, "_busy"}, 32'(busy),         32'd1);
      chk({tag, "_terr"}, 32'(tout_err),     32'd0);
      ack  = ($urandom_range(0, 99) < ack_pct);
      drop = (drop_after >= 0) && (beats >= drop_after);
      r = 9'($urandom);
      e = 9'($urandom);
      r[w] = 1'b1;
      e[w] = 1'b1;
      if (drop) begin
        if ($urandom_range(0, 1) == 0) r[w] = 1'b0;
        else                           e[w] = 1'b0;
      end
      ch_req      = r;
      ch_en       = e;
      burst_len   = 4'($urandom);
      bus.dma_ack = ack;
      if (ack && beats == blen)          done = 1;
      else if (drop)                     done = 1;
      else if (!ack && nack == TOUT - 1) begin done = 1; tout = 1; end
      if (ack) begin beats++; nack = 0; end
      else nack++;
      @(negedge clk);
    end
    if (!done) chk({tag, "_bound"}, 32'd0, 32'd1);
    if (tout) mt_ch = w;
    model_advance(w);
    // GAP cycle
    chk({tag, "_gap_req"},  32'(bus.dma_req), 32'd0);
    chk({tag, "_gap_gnt"},  32'(ch_grant),    32'd0);
    chk({tag, "_gap_busy"}, 32'(busy),        32'd1);
    chk({tag, "_gap_terr"}, 32'(tout_err),    32'(tout));
    chk({tag, "_gap_tch"},  32'(tout_ch),     32'(mt_ch));
    bus.dma_ack = 1'($urandom_range(0, 1));
    ch_req      = 9'($urandom);
    ch_en       = 9'($urandom);
    @(negedge clk);
    // IDLE cycle
    chk({tag, "_idl_req"},  32'(bus.dma_req), 32'd0);
    chk({tag, "_idl_busy"}, 32'(busy),        32'd0);
    chk({tag, "_idl_terr"}, 32'(tout_err),    32'd0);
    chk({tag, "_idl_tch"},  32'(tout_ch),     32'(mt_ch));
  endtask

  initial begin
    logic [8:0] r, e;
    rst = 1'b0; ch_req = '0; ch_en = '0; burst_len = '0; bus.dma_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req",  32'(bus.dma_req),  32'd0);
    chk("rst_ch",   32'(bus.dma_ch),   32'd0);
    chk("rst_last", 32'(bus.dma_last), 32'd0);
    chk("rst_gnt",  32'(ch_grant),     32'd0);
    chk("rst_busy", 32'(busy),         32'd0);
    chk("rst_terr", 32'(tout_err),     32'd0);
    chk("rst_tch",  32'(tout_ch),      32'd0);
    rst = 1'b1;

    // Two channels, full-rate acks, back-to-back bursts
    do_burst(9'h003, 9'h1FF, 3, 100, -1, "t1a");
    do_burst(9'h003, 9'h1FF, 3, 100, -1, "t1b");
    // Pointer wrap from 8 to 0
    do_burst(9'h080, 9'h1FF, 0, 100, -1, "t2a");
    do_burst(9'h101, 9'h1FF, 1, 100, -1, "t2b");
    do_burst(9'h101, 9'h1FF, 1, 100, -1, "t2c");
    // Beat timeout with no acks
    do_burst(9'h004, 9'h1FF, 5, 0, -1, "t3");
    // Request dropped after two acks, then search resumes above the dropped channel
    do_burst(9'h001, 9'h1FF, 7, 100, 2, "t4a");
    do_burst(9'h003, 9'h1FF, 2, 100, -1, "t4b");

    for (int i = 0; i < 40; i++) begin
      e = 9'($urandom) | (9'(1) << $urandom_range(0, 8));
      r = 9'($urandom);
      if ((r & e) == 9'h000) r = r | e;
      do_burst(r, e, $urandom_range(0, 15), $urandom_range(40, 100),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1, "rnd");
    end

    // Reset in the middle of a burst on channel 5
    ch_req = 9'h020; ch_en = 9'h1FF; burst_len = 4'd15; bus.dma_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t5_req", 32'(bus.dma_req), 32'd1);
      chk("t5_ch",  32'(bus.dma_ch),  32'd5);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_req",  32'(bus.dma_req), 32'd0);
    chk("t5_rst_gnt",  32'(ch_grant),    32'd0);
    chk("t5_rst_busy", 32'(busy),        32'd0);
    chk("t5_rst_tch",  32'(tout_ch),     32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Fresh reset: input priority decides between ch0 and ch8
    do_burst(9'h101, 9'h1FF, $urandom_range(0, 15), 100, -1, "t6");
    do_burst(9'h1FF, 9'h1FF, $urandom_range(0, 3), 80, -1, "t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
